mmio_uart_tx: RTL

// - Memory-mapped serial transmitter with a parametrised TX FIFO, a programmable baud divider and a readable status register.
// - Sits on the dmem bus behind the Mmu serial select and replaces the write-only serial sink.
// - The CPU pushes bytes without polling per bit. The block serialises them 8N1 (optionally 8E1) onto a single tx pin.

---
 rtl/mmio_uart_tx_pkg.sv | 30 +++
 rtl/mmio_uart_tx_if.sv | 21 ++
 rtl/mmio_uart_tx_fifo.sv | 62 ++++++
 rtl/mmio_uart_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mmio_uart_pkg
// Shared types and constants for the memory-mapped UART transmitter:
//   tx_state_e    - serialiser FSM states
//   REG_*         - register offsets decoded from addr[3:2]
//   STAT_*        - bit positions inside the STATUS register
// Optional feature macro used by the slice: UART_TX_PARITY_EN.
// ----------------------------------------------------------------------------
package mmio_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

endpackage

// File: rtl/mmio_uart_tx_if.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mmio_uart_tx_if
// dmem-side bus bundle for the UART transmitter.
//   sel  - Mmu select for this block
//   we   - write enable, qualified by sel
//   addr - byte address (only [3:2] decoded by the slave)
//   din  - write data
//   dout - read data, combinational, 0 when not selected
// Modports: master (CPU/Mmu side), slave (UART side).
// ----------------------------------------------------------------------------
interface mmio_uart_tx_if;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output sel, output we, output addr, output din, input dout);
  modport slave  (input sel, input we, input addr, input din, output dout);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head read.
//   clock, reset - system clock, synchronous active-high reset
//   push, wdata  - write request and data (ignored when full unless popping)
//   pop          - read request (ignored when empty)
//   rdata        - current head entry
//   full, empty  - occupancy flags
//   count        - entries held, 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [PW:0]      count_q;
  logic             wrEn;
  logic             rdEn;

  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign rdEn  = pop & ~empty;
  assign wrEn  = push & (~full | rdEn);
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rdPtr_q];

  // Pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (wrEn) wrPtr_q <= wrPtr_q + 1'b1;
      if (rdEn) rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, wrEn} - {{PW{1'b0}}, rdEn};
    end
  end

  // Storage needs no reset; only entries behind the write pointer are read.
  always_ff @(posedge clock) begin
    if (wrEn) mem_q[wrPtr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped serial transmitter: bytes pushed into a TX FIFO are sent
// 8N1 (8E1 with parity) on tx, one bit per DIV+1 clocks.
//   clock   - system clock
//   reset   - synchronous, active-high
//   bus     - mmio_uart_tx_if.slave (sel, we, addr, din, dout)
//   tx      - serial line, idle high
//   irq_txe - high while the FIFO is empty and the serialiser idle
// Registers (addr[3:2]): 0 DATA (W), 1 STATUS, 2 DIV, 3 reserved.
// Macro UART_TX_PARITY_EN adds an even-parity bit, enabled by DIV bit 16.
// ----------------------------------------------------------------------------
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int DATA_BITS   = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 86
) (
  input  logic            clock,
  input  logic            reset,
  mmio_uart_tx_if.slave   bus,
  output logic            tx,
  output logic            irq_txe
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(DATA_BITS);

  logic [1:0]           regSel;
  logic                 wrData, wrStatus, wrDiv;
  logic                 pop;
  logic [DATA_BITS-1:0] fifoHead;
  logic                 fifoFull, fifoEmpty;
  logic [CW-1:0]        fifoCount;
  logic                 busy, bitEnd, parEnable;
  logic                 unusedBits;

  logic                 overflow_q;
  logic [DIV_WIDTH-1:0] div_q;
  tx_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] curDiv_q, curDiv_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bitIdx_q, bitIdx_d;
  logic                 parity_q, parity_d;

  assign regSel     = bus.addr[3:2];
  assign wrData     = bus.sel & bus.we & (regSel == REG_DATA);
  assign wrStatus   = bus.sel & bus.we & (regSel == REG_STATUS);
  assign wrDiv      = bus.sel & bus.we & (regSel == REG_DIV);
  assign unusedBits = ^{bus.addr[31:4], bus.addr[1:0], bus.din};

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wrData),
    .pop   (pop),
    .wdata (bus.din[DATA_BITS-1:0]),
    .rdata (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // Overflow is sticky until software writes STATUS; a push that coincides
  // with a pop is accepted and never counts as overflow.
  always_ff @(posedge clock) begin
    if (reset)                           overflow_q <= 1'b0;
    else if (wrStatus)                   overflow_q <= 1'b0;
    else if (wrData & fifoFull & ~pop)   overflow_q <= 1'b1;
  end

  // Divisor register; the serialiser samples it only at bit boundaries.
  always_ff @(posedge clock) begin
    if (reset)      div_q <= DIV_WIDTH'(DEFAULT_DIV);
    else if (wrDiv) div_q <= bus.din[DIV_WIDTH-1:0];
  end

`ifdef UART_TX_PARITY_EN
  logic parEn_q;

  // Parity enable lives in DIV bit 16 regardless of the divisor width.
  always_ff @(posedge clock) begin
    if (reset)      parEn_q <= 1'b1;
    else if (wrDiv) parEn_q <= bus.din[16];
  end
  assign parEnable = parEn_q;
`else
  assign parEnable = 1'b0;
`endif

  // Serialiser state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      curDiv_q <= '0;
      shift_q  <= '0;
      bitIdx_q <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      curDiv_q <= curDiv_d;
      shift_q  <= shift_d;
      bitIdx_q <= bitIdx_d;
      parity_q <= parity_d;
    end
  end

  assign bitEnd = (cnt_q == curDiv_q);

  // Next-state logic. curDiv latches DIV at every bit boundary so a divisor
  // write mid-bit only affects the following bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    curDiv_d = curDiv_q;
    shift_d  = shift_q;
    bitIdx_d = bitIdx_q;
    parity_d = parity_q;
    pop      = 1'b0;

    if (state_q != IDLE) begin
      if (bitEnd) begin
        cnt_d    = '0;
        curDiv_d = div_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop      = 1'b1;
          state_d  = START;
          shift_d  = fifoHead;
          parity_d = ^fifoHead;
          cnt_d    = '0;
          curDiv_d = div_q;
        end
      end
      START: begin
        if (bitEnd) begin
          state_d  = DATA;
          bitIdx_d = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          shift_d = shift_q >> 1;
          if (bitIdx_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = parEnable ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bitEnd) state_d = STOP;
      end
      STOP: begin
        if (bitEnd) begin
          if (!fifoEmpty) begin
            pop      = 1'b1;
            state_d  = START;
            shift_d  = fifoHead;
            parity_d = ^fifoHead;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is a pure decode of the registered state.
  always_comb begin
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      PARITY:  tx = parity_q;
      default: tx = 1'b1;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign irq_txe = fifoEmpty & ~busy;

  // Read mux; everything reads 0 unless selected.
  always_comb begin
    bus.dout = '0;
    if (bus.sel) begin
      case (regSel)
        REG_STATUS: begin
          bus.dout[STAT_FULL]             = fifoFull;
          bus.dout[STAT_EMPTY]            = fifoEmpty;
          bus.dout[STAT_BUSY]             = busy;
          bus.dout[STAT_OVF]              = overflow_q;
          bus.dout[STAT_CNT_LSB +: 8]     = 8'(fifoCount);
        end
        REG_DIV: begin
          bus.dout[DIV_WIDTH-1:0] = div_q;
          bus.dout[16]            = parEnable;
        end
        default: bus.dout = '0;
      endcase
    end
  end

endmodule
